// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: lock-qualified start, h/v counters, registered sync/blank decode.
// Optional VGA_SYNC_PIPE_EN: delays hsync/vsync/blank_n one extra cycle to line up with a one-cycle pixel RAM read.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = !SYNC_ACT;

    localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          lock_meta, locked_s;
    logic [9:0]    h_cnt, v_cnt;
    logic          hsync_r, vsync_r, blank_r;

    // locked comes from the divider's own clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                if (locked_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = RUN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) state_d = WAIT_LOCK;
            end
            default: begin
                state_d  = WAIT_LOCK;
                settle_d = '0;
            end
        endcase
    end

    // Counters restart from (0,0) on every RUN entry; leaving RUN discards the position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_q == RUN && state_d == RUN) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r     <= SYNC_IDLE;
            vsync_r     <= SYNC_IDLE;
            blank_r     <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            running <= (state_d == RUN);
            if (state_q == RUN) begin
                hsync_r     <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_ACT : SYNC_IDLE;
                vsync_r     <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_ACT : SYNC_IDLE;
                blank_r     <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
                x           <= h_cnt;
                y           <= v_cnt;
                frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            end else begin
                hsync_r     <= SYNC_IDLE;
                vsync_r     <= SYNC_IDLE;
                blank_r     <= 1'b0;
                x           <= '0;
                y           <= '0;
                frame_start <= 1'b0;
            end
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    logic hsync_p, vsync_p, blank_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p <= SYNC_IDLE;
            vsync_p <= SYNC_IDLE;
            blank_p <= 1'b0;
        end else begin
            hsync_p <= hsync_r;
            vsync_p <= vsync_r;
            blank_p <= blank_r;
        end
    end

    assign hsync   = hsync_p;
    assign vsync   = vsync_p;
    assign blank_n = blank_p;
`else
    assign hsync   = hsync_r;
    assign vsync   = vsync_r;
    assign blank_n = blank_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a lock-streak/raster-position model feeds a queue checked by a monitor.
// Uses a shortened vertical raster so several frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 20, VF = 3, VS = 2, VB = 4;
    localparam int LW = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic ACT  = 1'b0;
    localparam logic IDLE = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       hsync, vsync, blank_n, frame_start, running;
    logic [9:0] x, y;

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       run;
    } exp_t;

    exp_t exp_q[$];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .LOCK_WAIT(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .x(x), .y(y), .frame_start(frame_start), .running(running)
    );

    initial forever #5 clk = ~clk;

    function automatic exp_t idle_out();
        exp_t d;
        d.hs = IDLE; d.vs = IDLE; d.bl = 1'b0;
        d.x = '0; d.y = '0; d.fs = 1'b0; d.run = 1'b0;
        return d;
    endfunction

    // Raster picture for the p-th cycle since RUN entry
    function automatic exp_t decode(input bit run, input int p);
        exp_t d;
        int h, v;
        d = idle_out();
        if (run) begin
            h = p % HT;
            v = (p / HT) % VT;
            d.x  = 10'(h);
            d.y  = 10'(v);
            d.bl = (h < HA) && (v < VA);
            d.hs = (h >= HA + HF && h < HA + HF + HS) ? ACT : IDLE;
            d.vs = (v >= VA + VF && v < VA + VF + VS) ? ACT : IDLE;
            d.fs = (h == 0) && (v == 0);
        end
        return d;
    endfunction

    // Model: RUN holds once locked has been seen (two edges late) for LW+1 edges in a row
    initial begin
        int   s0, s1, ls, streak, prev_p, p;
        bit   prev_run, in_run;
        exp_t prev_dec, cur_dec, e;
        s0 = 0; s1 = 0; streak = 0; prev_p = 0; prev_run = 0;
        prev_dec = idle_out();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                s0 = 0; s1 = 0; streak = 0; prev_p = 0; prev_run = 0;
                prev_dec = idle_out();
            end else begin
                ls = s1; s1 = s0; s0 = int'(locked);
                streak = (ls != 0) ? streak + 1 : 0;
                in_run = (streak >= LW + 1);
                p = in_run ? streak - LW - 1 : 0;
                cur_dec = decode(prev_run, prev_p);
                e = cur_dec;
`ifdef VGA_SYNC_PIPE_EN
                e.hs = prev_dec.hs;
                e.vs = prev_dec.vs;
                e.bl = prev_dec.bl;
`endif
                e.run = in_run;
                exp_q.push_back(e);
                prev_dec = cur_dec;
                prev_run = in_run;
                prev_p = p;
            end
        end
    end

    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            a = '{hs: hsync, vs: vsync, bl: blank_n, x: x, y: y, fs: frame_start, run: running};
            if (!rst_n) begin
                exp_q.delete();
                e = idle_out();
            end else if (exp_q.size() == 0) begin
                nvec++;
                nmis++;
                $display("[TB] FAIL scoreboard_underflow at %0t: got output with no expectation", $time);
                continue;
            end else begin
                e = exp_q.pop_front();
            end
            nvec++;
            if (a !== e) begin
                nmis++;
                $display("[TB] FAIL scoreboard at %0t: got hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b run=%b, expected hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b run=%b",
                         $time, a.hs, a.vs, a.bl, a.x, a.y, a.fs, a.run,
                         e.hs, e.vs, e.bl, e.x, e.y, e.fs, e.run);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic lk, input int cycles);
        @(negedge clk);
        #2;
        rst_n = r;
        locked = lk;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic checkOutput(input string name, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nmis++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Raise locked and return the edge index (0 = first sampling edge) where running is seen
    task automatic measureLock(output int run_edge);
        @(negedge clk);
        #2;
        locked = 1'b1;
        run_edge = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (running) begin
                run_edge = n;
                break;
            end
        end
    endtask

    initial begin
        int edge_n, cnt, hs_x;
        bit found;

        applyStimulus(1'b0, 1'b1, 6);
        #1;
        checkOutput("reset_hsync", int'(hsync), 1);
        checkOutput("reset_vsync", int'(vsync), 1);
        checkOutput("reset_blank_n", int'(blank_n), 0);
        checkOutput("reset_running", int'(running), 0);

        applyStimulus(1'b1, 1'b0, 5);
        measureLock(edge_n);
        checkOutput("lock_to_running_edge", edge_n, LW + 2);
        @(posedge clk);
        #1;
        checkOutput("first_frame_start", int'(frame_start), 1);
        checkOutput("first_x", int'(x), 0);
        checkOutput("first_y", int'(y), 0);
`ifdef VGA_SYNC_PIPE_EN
        checkOutput("first_blank_n_piped", int'(blank_n), 0);
`else
        checkOutput("first_blank_n", int'(blank_n), 1);
`endif

        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!frame_start && cnt < 2 * HT * VT);
        checkOutput("frame_period", cnt, HT * VT);

        hs_x = -1;
        for (int n = 0; n < 2 * HT; n++) begin
            @(posedge clk);
            #1;
            if (hsync == ACT) begin
                hs_x = int'(x);
                break;
            end
        end
`ifdef VGA_SYNC_PIPE_EN
        checkOutput("hsync_fall_x", hs_x, HA + HF + 1);
`else
        checkOutput("hsync_fall_x", hs_x, HA + HF);
`endif
        cnt = 1;
        while (hsync == ACT && cnt < 2 * HS) begin
            @(posedge clk);
            #1;
            if (hsync == ACT) cnt++;
            else break;
        end
        checkOutput("hsync_width", cnt, HS);

        found = 1'b0;
        for (int n = 0; n < 2 * HT * VT; n++) begin
            @(posedge clk);
            #1;
            if (y == 10'd10 && x == 10'd100) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_mid_frame", int'(found), 1);
        applyStimulus(1'b1, 1'b0, 4);
        #1;
        checkOutput("glitch_running_idle", int'(running), 0);
        checkOutput("glitch_x_idle", int'(x), 0);
        checkOutput("glitch_y_idle", int'(y), 0);

        applyStimulus(1'b1, 1'b0, 6);
        applyStimulus(1'b1, 1'b1, $urandom_range(3, 12));
        applyStimulus(1'b1, 1'b0, 5);
        measureLock(edge_n);
        checkOutput("settle_restart_edge", edge_n, LW + 2);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 5));
                applyStimulus(1'b1, locked, $urandom_range(1, 40));
            end else begin
                applyStimulus(1'b1, 1'b1, $urandom_range(10, 3000));
                applyStimulus(1'b1, 1'b0, $urandom_range(1, 30));
            end
        end
        applyStimulus(1'b1, 1'b1, 200);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
